// File: rtl/nn_harness_pkg.sv
// Shared types and defaults for the NN stream harness.
package nn_harness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    FIN
  } state_t;

  localparam int N_IN_DEF    = 10;
  localparam int W_DEF       = 18;
  localparam int DEPTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 1024;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_harness_vec_table.sv
// Vector table: input vector plus expected result per entry.
module nn_harness_vec_table
  import nn_harness_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int IW   = idx_w(DEPTH),
  localparam int DW   = N_IN * W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wr_in,
  input  logic [W-1:0]  wr_exp,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rd_in,
  output logic [W-1:0]  rd_exp
);

  logic [DW+W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {wr_exp, wr_in};
  end

  assign {rd_exp, rd_in} = mem[raddr];

endmodule

// File: rtl/nn_stream_harness.sv
// Initiator-side stimulus/check engine for the NN accelerator stream.
// Optional first-mismatch capture: NN_HARNESS_FIRST_ERR_CAPTURE_EN.
module nn_stream_harness
  import nn_harness_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int W       = W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IW     = idx_w(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int DW     = N_IN * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic [DW-1:0] tbl_in_dat,
  input  logic [W-1:0]  tbl_exp_dat,
  input  logic [CW-1:0] num_vec,
  input  logic          start,
  output logic [DW-1:0] dut_in_dat,
  output logic          dut_in_vld,
  input  logic          dut_in_rdy,
  input  logic [W-1:0]  dut_out_dat,
  input  logic          dut_out_vld,
  output logic          dut_out_rdy,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic          timeout,
  output logic [IW-1:0] cur_idx
`ifdef NN_HARNESS_FIRST_ERR_CAPTURE_EN
  ,
  output logic          first_err_vld,
  output logic [IW-1:0] first_err_idx,
  output logic [W-1:0]  first_err_got
`endif
);

  localparam int TW = idx_w(TIMEOUT);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] nvec_q, nvec_d;
  logic [CW-1:0] nvec_req;
  logic [CW-1:0] err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          pass_q, pass_d;
  logic          to_q, to_d;

  logic [DW-1:0] rd_in;
  logic [W-1:0]  rd_exp;
  logic          fire_in;
  logic          hit;
  logic          mis;
  logic          last;

  nn_harness_vec_table #(
    .N_IN  (N_IN),
    .W     (W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk    (clk),
    .we     (tbl_we && (state_q == IDLE)),
    .waddr  (tbl_addr),
    .wr_in  (tbl_in_dat),
    .wr_exp (tbl_exp_dat),
    .raddr  (idx_q),
    .rd_in  (rd_in),
    .rd_exp (rd_exp)
  );

  // Run length latched at start: 0 means 1, anything above DEPTH clamps.
  always_comb begin
    nvec_req = num_vec;
    if (num_vec == '0) nvec_req = CW'(1);
    else if (num_vec > CW'(DEPTH)) nvec_req = CW'(DEPTH);
  end

  assign dut_in_vld  = (state_q == SEND) && !reset;
  assign dut_out_rdy = (state_q == WAIT) && !reset;
  assign dut_in_dat  = dut_in_vld ? rd_in : '0;

  assign fire_in = dut_in_vld && dut_in_rdy;
  assign hit     = dut_out_vld && dut_out_rdy;
  assign mis     = hit && (dut_out_dat != rd_exp);
  assign last    = (idx_q == IW'(nvec_q - CW'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nvec_d  = nvec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
          nvec_d  = nvec_req;
          err_d   = '0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      SEND: begin
        if (fire_in) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (hit) begin
          if (mis && (err_q != CW'(DEPTH))) err_d = err_q + 1'b1;
          if (last) begin
            state_d = FIN;
            pass_d  = (err_d == '0) && !to_q;
          end else begin
            state_d = SEND;
            idx_d   = idx_q + 1'b1;
          end
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = FIN;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nvec_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nvec_q  <= nvec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  assign busy      = (state_q == SEND) || (state_q == WAIT);
  assign done      = (state_q == FIN);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign timeout   = to_q;
  assign cur_idx   = idx_q;

`ifdef NN_HARNESS_FIRST_ERR_CAPTURE_EN
  logic          fe_vld_q;
  logic [IW-1:0] fe_idx_q;
  logic [W-1:0]  fe_got_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
      fe_got_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
      fe_got_q <= '0;
    end else if (mis && !fe_vld_q) begin
      fe_vld_q <= 1'b1;
      fe_idx_q <= idx_q;
      fe_got_q <= dut_out_dat;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_got = fe_got_q;
`endif

endmodule
